coin_acceptor: RTL

Front-end stage of the vending machine datapath. It turns two raw coin-sensor lines (Rs5 chute and Rs10 chute) into the clean 2-bit coin code consumed by the vending FSM's `in` bus, which is 00 when there is no coin. Each physical coin produces exactly one single-cycle code. The block synchronizes and debounces the sensors, rejects glitches and simultaneous-chute events, detects jammed chutes, and keeps a running credit tally.

---
 rtl/vending_pkg.sv | 17 +
 rtl/sync_2ff.sv | 25 ++
 rtl/coin_acceptor.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/vending_pkg.sv
// Shared definitions for the vending machine datapath: the coin codes that
// travel on the vending FSM's `in` bus and the coin_acceptor state encoding.
package vending_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    typedef enum logic [2:0] {
        CA_IDLE     = 3'd0,
        CA_QUAL     = 3'd1,
        CA_EMIT     = 3'd2,
        CA_WAIT_REL = 3'd3,
        CA_JAM      = 3'd4
    } ca_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for an asynchronous sensor line.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops; the first may go metastable, the second settles it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: synchronizes and debounces the Rs5/Rs10 chute
// sensors, emits one single-cycle coin code per physical coin, detects jammed
// chutes and keeps a saturating credit tally in Rs5 units.
//
// Output handshake: coin_code is a valid strobe with no ready; a nonzero code
// is present for exactly one cycle per coin and the consumer must take it in
// that cycle. coin_total changes on the same edge that raises coin_code.
module coin_acceptor
    import vending_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int JAM_CYCLES      = 4096,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             coin5_raw,
    input  logic             coin10_raw,
    input  logic             accept_en,
    input  logic             jam_clr,
    input  logic             tally_clr,
    output logic [1:0]       coin_code,
    output logic             jam,
    output logic [CNT_W-1:0] coin_total,
    output logic [2:0]       dbg_state
);

    // Counter must reach JAM_CYCLES-1, the largest terminal count in use.
    localparam int CW = $clog2(JAM_CYCLES + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] JAM_LAST = CW'(JAM_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic s5;
    logic s10;

    ca_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sel10_q, sel10_d;
    logic             hi_run_q, hi_run_d;   // 1: cnt is timing a high run in WAIT_REL
    logic [1:0]       code_q, code_d;
    logic             jam_q, jam_d;
    logic [CNT_W-1:0] total_q, total_d;

    logic             credit;
    logic             s_sel;
    logic             s_oth;
    logic             any_hi;
    logic [CNT_W:0]   credit_amt;
    logic [CNT_W:0]   total_sum;

    sync_2ff u_sync5 (
        .clk (clk),
        .rst (rst),
        .d   (coin5_raw),
        .q   (s5)
    );

    sync_2ff u_sync10 (
        .clk (clk),
        .rst (rst),
        .d   (coin10_raw),
        .q   (s10)
    );

    assign s_sel      = sel10_q ? s10 : s5;
    assign s_oth      = sel10_q ? s5  : s10;
    assign any_hi     = s5 | s10;
    assign credit_amt = {{(CNT_W-1){1'b0}}, sel10_q, ~sel10_q};
    assign total_sum  = {1'b0, total_q} + credit_amt;

    // Next-state, counter, coin code and tally update.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel10_d  = sel10_q;
        hi_run_d = hi_run_q;
        code_d   = COIN_NONE;
        credit   = 1'b0;

        case (state_q)
            CA_IDLE: begin
                cnt_d = '0;
                if ((s5 && s10) || (any_hi && !accept_en)) begin
                    // Simultaneous chutes or disabled acceptance: swallow the coin.
                    state_d  = CA_WAIT_REL;
                    hi_run_d = 1'b1;
                end else if (any_hi) begin
                    state_d = CA_QUAL;
                    sel10_d = s10;
                end
            end

            CA_QUAL: begin
                if (!s_sel || s_oth) begin
                    state_d = CA_IDLE;
                    cnt_d   = '0;
                end else if (!accept_en) begin
                    state_d  = CA_WAIT_REL;
                    cnt_d    = '0;
                    hi_run_d = 1'b1;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = CA_EMIT;
                    cnt_d   = '0;
                    code_d  = sel10_q ? COIN_10 : COIN_5;
                    credit  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            CA_EMIT: begin
                state_d  = CA_WAIT_REL;
                cnt_d    = '0;
                hi_run_d = 1'b1;
            end

            CA_WAIT_REL: begin
                if (any_hi) begin
                    if (!hi_run_q) begin
                        hi_run_d = 1'b1;
                        cnt_d    = CNT_ONE;
                    end else if (cnt_q == JAM_LAST) begin
                        state_d = CA_JAM;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    if (hi_run_q) begin
                        hi_run_d = 1'b0;
                        cnt_d    = CNT_ONE;
                    end else if (cnt_q == DEB_LAST) begin
                        state_d = CA_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end

            CA_JAM: begin
                if (jam_clr && !any_hi) begin
                    state_d = CA_IDLE;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = CA_IDLE;
                cnt_d   = '0;
            end
        endcase

        jam_d = (state_d == CA_JAM);

        // A clear on the crediting edge wins over the add.
        total_d = total_q;
        if (tally_clr) begin
            total_d = '0;
        end else if (credit) begin
            total_d = total_sum[CNT_W] ? {CNT_W{1'b1}} : total_sum[CNT_W-1:0];
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= CA_IDLE;
            cnt_q    <= '0;
            sel10_q  <= 1'b0;
            hi_run_q <= 1'b0;
            code_q   <= COIN_NONE;
            jam_q    <= 1'b0;
            total_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel10_q  <= sel10_d;
            hi_run_q <= hi_run_d;
            code_q   <= code_d;
            jam_q    <= jam_d;
            total_q  <= total_d;
        end
    end

    assign coin_code  = code_q;
    assign jam        = jam_q;
    assign coin_total = total_q;
    assign dbg_state  = state_q;

endmodule
